// File: rtl/alu_pkg.sv
// Shared ALU Operation codes, ALUOp encodings and funct3 constants used by the
// execute-stage issue logic.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_EQ      = 4'b1000,
        ALU_SLT     = 4'b1100,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_ADDR   = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_ARITH  = 2'b10,
        ALUOP_LUI    = 2'b11
    } aluop_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/alu_op_encode.sv
// Combinational ALUOp/Funct3/Funct7/ALUSrc to ALU Operation encoder; unmapped
// combinations yield ALU_ILLEGAL with illegal_o set.
module alu_op_encode
    import alu_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       alusrc_i,
    output alu_op_e    op_o,
    output logic       illegal_o
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        op_o = ALU_ILLEGAL;
        case (aluop_i)
            ALUOP_ADDR, ALUOP_LUI: op_o = ALU_ADD;
            ALUOP_BRANCH: begin
                // BNE/BGE share codes with BEQ/BLT; EX inverts the flag.
                case (funct3_i)
                    F3_BEQ, F3_BNE: op_o = ALU_EQ;
                    F3_BLT, F3_BGE: op_o = ALU_SLT;
                    default:        op_o = ALU_ILLEGAL;
                endcase
            end
            default: begin
                case (funct3_i)
                    F3_ADD_SUB: op_o = (funct7_i[5] && !alusrc_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     op_o = ALU_SLL;
                    F3_SLT:     op_o = ALU_SLT;
                    F3_XOR:     op_o = ALU_XOR;
                    F3_SRL_SRA: op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:      op_o = ALU_OR;
                    F3_AND:     op_o = ALU_AND;
                    default:    op_o = ALU_ILLEGAL;
                endcase
            end
        endcase
        illegal_o = (op_o == ALU_ILLEGAL);
    end

endmodule

// File: rtl/alu_op_issue.sv
// Execute-stage issue register: valid/ready handshake, operand select and
// registered ALU Operation. Define ALU_ISSUE_SKID_EN for a registered in_ready.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     illegal
);

    typedef struct packed {
        alu_op_e               op;
        logic                  ill;
        logic [DATA_WIDTH-1:0] srca;
        logic [DATA_WIDTH-1:0] srcb;
    } issue_t;

    alu_op_e enc_op;
    logic    enc_ill;
    issue_t  in_pld;

    alu_op_encode u_encode (
        .aluop_i   (aluop_e'(ALUOp)),
        .funct3_i  (Funct3),
        .funct7_i  (Funct7),
        .alusrc_i  (ALUSrc),
        .op_o      (enc_op),
        .illegal_o (enc_ill)
    );

    always_comb begin
        in_pld.op   = enc_op;
        in_pld.ill  = enc_ill;
        in_pld.srca = (aluop_e'(ALUOp) == ALUOP_LUI) ? '0 : RD1;
        in_pld.srcb = ALUSrc ? Imm : RD2;
    end

    logic   valid_q, valid_d;
    issue_t main_q, main_d;

`ifdef ALU_ISSUE_SKID_EN
    logic   skid_valid_q, skid_valid_d;
    issue_t skid_q, skid_d;
    logic   ready_q, ready_d;
    logic   accept;
    logic   advance;

    assign in_ready = ready_q;
    assign accept   = in_valid && ready_q && !flush;
    assign advance  = !valid_q || out_ready;

    // The skid entry only fills while the main stage stalls, and drains
    // into the main stage before any new input is accepted.
    always_comb begin
        valid_d      = valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d  = in_pld;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_pld;
            skid_valid_d = 1'b1;
        end
        ready_d    = !skid_valid_d;
        main_d.ill = main_d.ill & valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ready_q      <= ready_d;
        end
    end
`else
    logic load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            main_d  = in_pld;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        main_d.ill = main_d.ill & valid_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    assign out_valid = valid_q;
    assign Operation = OPCODE_LENGTH'(main_q.op);
    assign SrcA      = main_q.srca;
    assign SrcB      = main_q.srcb;
    assign illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomised and directed bench for alu_op_issue against a transaction-queue
// reference model; honours ALU_ISSUE_SKID_EN for the expected buffer depth.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        ALUSrc;
    logic [31:0] RD1, RD2, Imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic [3:0]  op;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .ALUSrc    (ALUSrc),
        .RD1       (RD1),
        .RD2       (RD2),
        .Imm       (Imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic src,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] imm);
        exp_t e;
        e.a = (aop == 2'd3) ? 32'd0 : rd1;
        e.b = src ? imm : rd2;
        if (aop == 2'd0 || aop == 2'd3) begin
            e.op = 4'h2;
        end else if (aop == 2'd1) begin
            if (f3 == 3'd0 || f3 == 3'd1)      e.op = 4'h8;
            else if (f3 == 3'd4 || f3 == 3'd5) e.op = 4'hC;
            else                               e.op = 4'hF;
        end else begin
            case (f3)
                3'd0:    e.op = (f7[5] && !src) ? 4'h6 : 4'h2;
                3'd1:    e.op = 4'h4;
                3'd2:    e.op = 4'hC;
                3'd3:    e.op = 4'hF;
                3'd4:    e.op = 4'h3;
                3'd5:    e.op = f7[5] ? 4'h7 : 4'h5;
                3'd6:    e.op = 4'h1;
                default: e.op = 4'h0;
            endcase
        end
        e.ill = (e.op == 4'hF);
        return e;
    endfunction

    task automatic set_in(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm);
        ALUOp = aop; Funct3 = f3; Funct7 = f7; ALUSrc = src;
        RD1 = rd1; RD2 = rd2; Imm = imm;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle();
        logic fire, consume;
        @(negedge clk);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("Operation", Operation, exp_q[0].op);
            check("SrcA", SrcA, exp_q[0].a);
            check("SrcB", SrcB, exp_q[0].b);
            check("illegal", illegal, exp_q[0].ill);
        end else begin
            check("illegal_idle", illegal, 1'b0);
        end
`ifdef ALU_ISSUE_SKID_EN
        check("in_ready", in_ready, exp_q.size() < DEPTH);
`else
        check("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
`endif
        fire    = in_valid && in_ready && !flush;
        consume = out_valid && out_ready;
        if (consume && exp_q.size() != 0) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (fire) exp_q.push_back(model(ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, Imm));
        @(posedge clk);
        #1;
    endtask

    task automatic issue1(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm);
        set_in(aop, f3, f7, src, rd1, rd2, imm);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        set_in(2'd0, 3'd0, 7'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_op", Operation, 4'b0000);
        check("rst_srca", SrcA, 32'd0);
        check("rst_srcb", SrcB, 32'd0);
        check("rst_illegal", illegal, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue1(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd10, 32'd3, 32'd0);
        check("sub_valid", out_valid, 1'b1);
        check("sub_op", Operation, 4'b0110);
        check("sub_srca", SrcA, 32'd10);
        check("sub_srcb", SrcB, 32'd3);
        issue1(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd10, 32'd3, 32'hFFFFFFE0);
        check("addi_op", Operation, 4'b0010);
        check("addi_srcb", SrcB, 32'hFFFFFFE0);
        issue1(2'b01, 3'b101, 7'd0, 1'b0, 32'd5, 32'd6, 32'd0);
        check("bge_op", Operation, 4'b1100);
        issue1(2'b01, 3'b011, 7'd0, 1'b0, 32'd5, 32'd6, 32'd0);
        check("br_ill_op", Operation, 4'b1111);
        check("br_ill_flag", illegal, 1'b1);
        issue1(2'b11, 3'b010, 7'd0, 1'b1, 32'hDEADBEEF, 32'd1, 32'h12345000);
        check("lui_op", Operation, 4'b0010);
        check("lui_srca", SrcA, 32'd0);
        check("lui_srcb", SrcB, 32'h12345000);

        // Stall a held SLL for three cycles with a pending XOR.
        issue1(2'b10, 3'b001, 7'd0, 1'b1, 32'd1, 32'd0, 32'd4);
        check("sll_op", Operation, 4'b0100);
        set_in(2'b10, 3'b100, 7'd0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0);
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("stall_op", Operation, 4'b0100);
            check("stall_valid", out_valid, 1'b1);
        end
`ifndef ALU_ISSUE_SKID_EN
        check("stall_in_ready", in_ready, 1'b0);
`endif
        out_ready = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
        in_valid = 1'b0;
`endif
        cycle();
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_op", Operation, 4'b0011);
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();

        // Flush with a held XOR and an acceptable incoming instruction.
        set_in(2'b00, 3'b000, 7'd0, 1'b1, 32'd7, 32'd0, 32'd9);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        cycle();
        check("flush_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        cycle();

        // Asynchronous reset with an instruction held.
        issue1(2'b10, 3'b110, 7'd0, 1'b0, 32'h11, 32'h22, 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        check("pre_reset_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_op", Operation, 4'b0000);
        check("async_rst_illegal", illegal, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 400; i++) begin
            set_in(2'($urandom), 3'($urandom), ($urandom % 2) ? 7'b0100000 : 7'($urandom),
                   1'($urandom), $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
        cycle();
        check("drain_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
Execute-stage issue register feeding the combinational ALU. It accepts decoded instructions from ID via valid/ready, encodes ALUOp/funct3/funct7 into the ALU's 4-bit Operation code, selects SrcA/SrcB, and holds the result in a pipeline register with stall and flush. It is the encoder side of the ALU Operation interface.

Parameters:
DATA_WIDTH, 32, operand width
OPCODE_LENGTH, 4, Operation code width (ALU interface)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  ID holds a valid instruction
in_ready  out  1  issue register can accept this cycle
ALUOp  in  2  00 addr-add, 01 branch, 10 R/I arith, 11 LUI
Funct3  in  3  instr[14:12]
Funct7  in  7  instr[31:25]
ALUSrc  in  1  1 = SrcB from Imm (I-type), 0 = from RD2
RD1  in  DATA_WIDTH  rs1 data
RD2  in  DATA_WIDTH  rs2 data
Imm  in  DATA_WIDTH  sign-extended immediate
flush  in  1  kill held and incoming instruction
out_valid  out  1  Operation/SrcA/SrcB valid to EX
out_ready  in  1  EX consumes this cycle
Operation  out  OPCODE_LENGTH  ALU code
SrcA  out  DATA_WIDTH  ALU operand A
SrcB  out  DATA_WIDTH  ALU operand B
illegal  out  1  held instruction has no ALU encoding

Behaviour:
- Reset (async assert, sync release): out_valid=0, Operation=4'b0000, SrcA=0, SrcB=0, illegal=0.
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, SLT 1100; illegal drives 1111 (ALU returns 0).
- Encode: ALUOp 00 -> ADD. ALUOp 11 -> ADD with SrcA forced 0. ALUOp 01: Funct3 000/001 -> EQ (BNE inversion is EX's job), 100/101 -> SLT, others illegal. ALUOp 10: 000 ADD, or SUB if Funct7[5] && !ALUSrc; 001 SLL; 010 SLT; 100 XOR; 101 SRA if Funct7[5] else SRL (shamt from Imm when ALUSrc=1); 110 OR; 111 AND; 011 (SLTU) illegal.
- Funct7 is ignored except bit 5 in the cases above.
- SrcB = ALUSrc ? Imm : RD2. SrcA = RD1 except LUI.
- Handshake: in_ready = !out_valid || out_ready. Load on in_valid && in_ready. Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- out_valid clears when out_ready is high and no new load occurs.
- Stall: out_valid && !out_ready holds all outputs stable and in_ready=0.
- Simultaneous consume and load in the same cycle: back-to-back, no bubble.
- flush: next edge out_valid=0, and the incoming instruction is discarded even if in_valid && in_ready. Data registers need not clear. flush has priority over load and stall.
- Outputs are registered. No combinational path from in_* to Operation/SrcA/SrcB.
- Illegal instructions still handshake normally. illegal follows out_valid.
- Reset mid-stall drops the held instruction.

Optional Feature:
ALU_ISSUE_SKID_EN: when defined, adds a one-entry skid buffer so in_ready is a pure register output (no out_ready->in_ready combinational path). Throughput stays one per cycle, and up to one extra instruction is buffered while EX stalls. flush clears both entries. When undefined, only the single register stage with combinational in_ready exists.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with the 4-bit codes above, including ALU_ILLEGAL=4'b1111.
  - aluop_e enum for the 2-bit ALUOp.
  - funct3 constants.
- Sub-module alu_op_encode: purely combinational ALUOp/Funct3/Funct7/ALUSrc -> {Operation, illegal}.
- The top level holds the handshake, skid buffer and registers.

Test Plan:
- Reset asserted mid-cycle with out_valid=1 -> out_valid=0, Operation=0000 immediately, without waiting for a clock edge.
- ALUOp=10, Funct3=000, Funct7=0100000, ALUSrc=0, RD1=10, RD2=3, out_ready=1 -> next cycle Operation=0110, SrcA=10, SrcB=3, out_valid=1. Same stimulus with ALUSrc=1, Imm=-32 -> Operation=0010, SrcB=32'hFFFFFFE0.
- ALUOp=01, Funct3=101 -> Operation=1100. Funct3=011 -> Operation=1111, illegal=1. ALUOp=11, Imm=32'h12345000 -> Operation=0010, SrcA=0.
- out_ready=0 for 3 cycles with a held SLL, in_valid=1 -> outputs stable, in_ready=0. Release -> SLL consumed, and the next instruction loads the same cycle with no bubble.
- flush asserted together with in_valid=1, in_ready=1 -> next cycle out_valid=0, and neither the incoming nor the held instruction appears.
- Streaming 8 back-to-back ops with out_ready toggling randomly -> every instruction delivered exactly once, in order. Repeat with ALU_ISSUE_SKID_EN defined.
